// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 9-bit control sequencer: opcodes, sub-opcodes,
// ALU class selects, FSM states and the instruction decode helpers.
package isa_pkg;

    // Major opcode, instr[8:6]. Non-zero values are ALU function selects.
    typedef enum logic [2:0] {
        OP_SYS = 3'b000,
        OP_SHL = 3'b001,
        OP_SHR = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_ADD = 3'b101,
        OP_NOP = 3'b110,
        OP_PAR = 3'b111
    } op_e;

    // Sub-opcode of OP_SYS, instr[5:3]; operand register is instr[2:0].
    typedef enum logic [2:0] {
        SUB_DEC  = 3'b000,
        SUB_INC  = 3'b001,
        SUB_CMP  = 3'b010,
        SUB_BZ   = 3'b011,
        SUB_LD   = 3'b100,
        SUB_ST   = 3'b101,
        SUB_RSV  = 3'b110,
        SUB_HALT = 3'b111
    } subop_e;

    // ALU class selects.
    localparam logic [1:0] ALUOP_FUNC = 2'b00;
    localparam logic [1:0] ALUOP_DEC  = 2'b01;
    localparam logic [1:0] ALUOP_INC  = 2'b10;
    localparam logic [1:0] ALUOP_XOR  = 2'b11;

    // ALU function code that leaves the datapath idle.
    localparam logic [2:0] ALU_CMD_NOP = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FETCH = 3'b001,
        ST_EXEC  = 3'b010,
        ST_WB    = 3'b011,
        ST_DONE  = 3'b100
    } state_e;

    // Datapath controls produced by decode; enables are gated to WB by the caller.
    typedef struct packed {
        logic [2:0] alu_cmd;
        logic [1:0] alu_op;
        logic [2:0] addr_a;
        logic [2:0] addr_b;
        logic       rf_wr;
        logic [2:0] wr_addr;
        logic       wr_sel;
        logic       mem_wr;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        alu_cmd: ALU_CMD_NOP,
        alu_op:  ALUOP_FUNC,
        addr_a:  3'd0,
        addr_b:  3'd0,
        rf_wr:   1'b0,
        wr_addr: 3'd0,
        wr_sel:  1'b0,
        mem_wr:  1'b0
    };

    function automatic ctrl_t decode(input logic [8:0] ir);
        ctrl_t c;
        op_e   op;
        subop_e sub;
        c   = CTRL_IDLE;
        op  = op_e'(ir[8:6]);
        sub = subop_e'(ir[5:3]);
        if (op != OP_SYS) begin
            // ALU function: A=ra, B=rb, result back to ra unless NOP
            c.alu_cmd = ir[8:6];
            c.addr_a  = ir[5:3];
            c.addr_b  = ir[2:0];
            c.wr_addr = ir[5:3];
            c.rf_wr   = (op != OP_NOP);
        end else begin
            case (sub)
                SUB_DEC: begin
                    c.alu_op  = ALUOP_DEC;
                    c.addr_a  = ir[2:0];
                    c.wr_addr = ir[2:0];
                    c.rf_wr   = 1'b1;
                end
                SUB_INC: begin
                    c.alu_op  = ALUOP_INC;
                    c.addr_a  = ir[2:0];
                    c.wr_addr = ir[2:0];
                    c.rf_wr   = 1'b1;
                end
                SUB_CMP: begin
                    c.alu_op = ALUOP_XOR;
                    c.addr_b = ir[2:0];
                end
                SUB_LD: begin
                    c.addr_b  = ir[2:0];
                    c.wr_sel  = 1'b1;
                    c.rf_wr   = 1'b1;
                end
                SUB_ST: begin
                    c.addr_b = ir[2:0];
                    c.mem_wr = 1'b1;
                end
                default: ; // BZ, reserved and HALT drive no datapath
            endcase
        end
        return c;
    endfunction

    // Instructions whose EXEC result updates the zero flag.
    function automatic logic sets_flag(input logic [8:0] ir);
        if (ir[8:6] != OP_SYS)
            return (ir[8:6] != OP_NOP);
        return (ir[5:3] == SUB_DEC) || (ir[5:3] == SUB_INC) || (ir[5:3] == SUB_CMP);
    endfunction

    function automatic logic is_bz(input logic [8:0] ir);
        return (ir[8:6] == OP_SYS) && (ir[5:3] == SUB_BZ);
    endfunction

    function automatic logic is_halt(input logic [8:0] ir);
        return (ir[8:6] == OP_SYS) && (ir[5:3] == SUB_HALT);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Eight-entry combinational branch target table indexed by the BZ operand field.
module branch_lut #(
    parameter int                  PC_W    = 10,
    parameter logic [8*PC_W-1:0]   TARGETS = '0
) (
    input  logic [2:0]       idx,
    output logic [PC_W-1:0]  target
);

    logic [PC_W-1:0] table_w [8];

    // Unpack the flat parameter into one entry per index.
    for (genvar gi = 0; gi < 8; gi++) begin : g_entry
        assign table_w[gi] = TARGETS[gi*PC_W +: PC_W];
    end

    assign target = table_w[idx];

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit: FETCH/EXEC/WB per instruction, zero-flag branches,
// one program per start/done handshake. All outputs are registered.
module ctrl_sequencer
    import isa_pkg::*;
#(
    parameter int                PC_W       = 10,
    parameter logic [8*PC_W-1:0] BR_TARGETS = {PC_W'(140), PC_W'(120), PC_W'(100), PC_W'(80),
                                               PC_W'(60),  PC_W'(40),  PC_W'(20),  PC_W'(0)}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic             zero,
    output logic [PC_W-1:0]  prog_ctr,
    output logic [2:0]       alu_cmd,
    output logic [1:0]       ALU_Op,
    output logic [2:0]       rf_addr_a,
    output logic [2:0]       rf_addr_b,
    output logic             rf_wr_en,
    output logic [2:0]       rf_wr_addr,
    output logic             rf_wr_sel,
    output logic             mem_wr_en,
    output logic             done
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            flag_q, flag_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            done_q, done_d;

    ctrl_t           dec_ir;
    ctrl_t           dec_instr;
    ctrl_t           ctrl_sel;
    logic [PC_W-1:0] br_target;

    branch_lut #(
        .PC_W    (PC_W),
        .TARGETS (BR_TARGETS)
    ) u_branch_lut (
        .idx    (ir_q[2:0]),
        .target (br_target)
    );

    assign dec_ir    = decode(ir_q);
    assign dec_instr = decode(instr);

    // Next-state, PC/IR/flag update and next registered control outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flag_d  = flag_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    flag_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (sets_flag(ir_q))
                    flag_d = zero;
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_d    = (is_bz(ir_q) && flag_q) ? br_target : pc_q + PC_W'(1);
                state_d = is_halt(ir_q) ? ST_DONE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        // Controls for the coming cycle: EXEC decodes the word being latched,
        // WB keeps decoding IR and opens the write enables for one cycle.
        ctrl_sel = CTRL_IDLE;
        if (state_d == ST_EXEC)
            ctrl_sel = dec_instr;
        else if (state_d == ST_WB)
            ctrl_sel = dec_ir;
        ctrl_d        = ctrl_sel;
        ctrl_d.rf_wr  = ctrl_sel.rf_wr  && (state_d == ST_WB);
        ctrl_d.mem_wr = ctrl_sel.mem_wr && (state_d == ST_WB);
        done_d        = (state_d == ST_DONE);
    end

    // State, program counter, instruction register, flag and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flag_q  <= 1'b0;
            ctrl_q  <= CTRL_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flag_q  <= flag_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    assign prog_ctr   = pc_q;
    assign alu_cmd    = ctrl_q.alu_cmd;
    assign ALU_Op     = ctrl_q.alu_op;
    assign rf_addr_a  = ctrl_q.addr_a;
    assign rf_addr_b  = ctrl_q.addr_b;
    assign rf_wr_en   = ctrl_q.rf_wr;
    assign rf_wr_addr = ctrl_q.wr_addr;
    assign rf_wr_sel  = ctrl_q.wr_sel;
    assign mem_wr_en  = ctrl_q.mem_wr;
    assign done       = done_q;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control unit that issues commands to the 8-bit ALU. It fetches 9-bit instructions, decodes them into `alu_cmd`/`ALU_Op`, register-file addresses and memory/write-back enables, latches the ALU `zero` flag, and resolves branches. It sits between instruction ROM, register file, data memory and ALU in the processor top level, and runs one program per `start`/`done` handshake.

## Interface
- `PC_W`, default 10: program counter width.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE or DONE to launch the program from PC 0.
- `instr`  in  9  instruction ROM data; ROM is combinational on `prog_ctr`.
- `zero`  in  1  ALU zero output (result == 0).
- `prog_ctr`  out  PC_W  instruction address.
- `alu_cmd`  out  3  ALU function select.
- `ALU_Op`  out  2  ALU class select (00 function, 01 dec, 10 inc, 11 xor/compare).
- `rf_addr_a`, `rf_addr_b`  out  3 each  register-file read addresses (feed ALU inA/inB).
- `rf_wr_en`  out  1  register write enable; `rf_wr_addr`  out  3; `rf_wr_sel`  out  1 (0 = ALU result, 1 = data memory).
- `mem_wr_en`  out  1  data memory write (address R[rf_addr_b], data R[rf_addr_a]).
- `done`  out  1  program halted.

## Operation
- Encoding: `instr[8:6]` op, `[5:3]` ra, `[2:0]` rb.
- op 001–111: ALU function op; `alu_cmd`=op, `ALU_Op`=00, A=ra, B=rb, write ALU result to ra (110 is NOP: no write). op 111 (parity) writes `{7'b0, ^R[rb]}` to ra.
- op 000, sub-op `[5:3]`, operand field rb:
  - 000 DEC: `ALU_Op`=01, A=rb, write to rb.
  - 001 INC: `ALU_Op`=10, A=rb, write to rb.
  - 010 CMP: `ALU_Op`=11, A=r0, B=rb; no write; sets flag.
  - 011 BZ: if flag=1, PC <= branch_lut[rb], else PC+1.
  - 100 LD: B=rb; r0 <= mem[R[rb]] (`rf_wr_sel`=1).
  - 101 ST: A=r0, B=rb; mem[R[rb]] <= R[r0].
  - 110 reserved: treated as NOP. 111 HALT: enter DONE.
- FSM: IDLE -> FETCH -> EXEC -> WB -> FETCH; WB -> DONE on HALT; IDLE/DONE -> FETCH on `start` (PC <= 0, flag <= 0).
- FETCH: latch `instr` into IR. EXEC and WB: drive decoded ALU controls and addresses from IR. EXEC end: flag <= `zero` for ALU function ops (except NOP), INC, DEC, CMP; otherwise flag held.
- WB: single-cycle pulse of `rf_wr_en`/`mem_wr_en` as decoded; PC update (PC+1 or branch target). PC wraps 2^PC_W−1 -> 0.
- Outside EXEC/WB: `alu_cmd`=110, `ALU_Op`=00, all enables 0, addresses 0.

## Timing
- Reset (synchronous, any state): state IDLE, `prog_ctr`=0, IR=0, flag=0, `done`=0, all enables 0, `alu_cmd`=110, `ALU_Op`=00. Reset wins over `start`.
- Each instruction takes exactly 3 cycles (FETCH, EXEC, WB); HALT asserts `done` from the cycle after its WB.
- `start` high in IDLE: FETCH next cycle with `prog_ctr`=0. `done` stays high in DONE until `start` samples high; it drops in the same cycle FETCH begins.
- `start` is ignored while in FETCH/EXEC/WB.
- Outputs are registered state or combinational decode of IR plus state only; no combinational path from `zero` to any output.

## Structure
- Shared package `isa_pkg`: op and sub-op codes, `ALU_Op` constants, ALU function codes (001 shl … 111 parity, 110 NOP), FSM state enum {IDLE, FETCH, EXEC, WB, DONE}.
- Sub-module `branch_lut`: 8-entry combinational table rb -> PC_W-bit target, contents set per program.
- Top `ctrl_sequencer`: FSM, IR, PC, flag, decode.

## Test plan
- Reset then `start`: `prog_ctr`=0, 3 cycles later `prog_ctr`=1; `instr`=9'b011_001_010 (AND r1,r2) -> EXEC/WB `alu_cmd`=011, `ALU_Op`=00, addrs 1/2, `rf_wr_en` pulse in WB to r1.
- INC r5 (9'b000_001_101) -> `ALU_Op`=10, `rf_addr_a`=5, write r5; DEC -> `ALU_Op`=01.
- CMP r3 with `zero`=1, then BZ 2 with branch_lut[2]=10'd40 -> `prog_ctr`=40 after BZ WB; repeat with `zero`=0 -> PC+1.
- LD r4 then ST r4: LD -> `rf_wr_sel`=1, `rf_wr_addr`=0, `rf_addr_b`=4; ST -> `mem_wr_en` one-cycle pulse, `rf_addr_a`=0, `rf_wr_en`=0.
- HALT -> `done`=1, held with `start`=0 for 10 cycles; `start`=1 -> `done`=0, `prog_ctr`=0, flag cleared.
- Assert `reset` during EXEC of a write op -> no `rf_wr_en` pulse, next cycle all outputs at reset values; PC at 1023 with NOP -> wraps to 0.
